// File: rtl/mil_receiver_if.sv
// mil_receiver_if
//   Bundles the transceiver receive pins with the decoded-word push path.
//   master : the receiver (samples milP/milN, drives the word outputs)
//   slave  : line driver / word consumer side
//   Signals:
//     milP, milN  transceiver RX outputs (asynchronous to clk)
//     rxValid     one-cycle strobe, word available
//     rxService   1 = command/status sync, 0 = data sync
//     rxData      decoded word, first-received bit in [15]
//     rxError     word decoded with error
//     rxErrCode   01 Manchester error, 10 parity error, 00 clean
//     busy        receiver engaged from sync start until word end/abort
interface mil_receiver_if;
  logic        milP;
  logic        milN;
  logic        rxValid;
  logic        rxService;
  logic [15:0] rxData;
  logic        rxError;
  logic [1:0]  rxErrCode;
  logic        busy;

  modport master (
    input  milP, milN,
    output rxValid, rxService, rxData, rxError, rxErrCode, busy
  );

  modport slave (
    output milP, milN,
    input  rxValid, rxService, rxData, rxError, rxErrCode, busy
  );
endinterface

// File: rtl/mil_receiver.sv
// mil_receiver
//   MIL-STD-1553 Manchester-II word receiver. Oversamples the transceiver
//   outputs on clk, detects command/status or data sync, decodes 16 data bits
//   plus odd parity and pushes one word per rxValid strobe.
//   Ports:
//     clk   system clock (HALF clocks per 0.5 us half-bit)
//     nRst  asynchronous active-low reset
//     bus   mil_receiver_if.master (line inputs, word outputs, busy)
//   Parameters:
//     HALF  clocks per half-bit
//     TOL   allowed deviation (clocks) on sync length and mid-bit resync
module mil_receiver #(
  parameter int HALF = 25,
  parameter int TOL  = 4
) (
  input logic            clk,
  input logic            nRst,
  mil_receiver_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_SYNC1, S_SYNC2, S_BIT, S_GAP} state_t;
  typedef enum logic [1:0] {LV_IDLE, LV_HI, LV_LO} lvl_t;

  localparam int CW = $clog2(3*HALF + TOL + 2);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] SYNC_MIN  = CW'(3*HALF - TOL);
  localparam logic [CW-1:0] SYNC_MAX  = CW'(3*HALF + TOL);
  localparam logic [CW-1:0] SYNC2_END = CW'(3*HALF - 1);
  localparam logic [CW-1:0] PH_LAST   = CW'(HALF - 1);
  localparam logic [CW-1:0] PH_SAMP   = CW'(HALF / 2);
  localparam logic [CW-1:0] WIN_LO    = CW'(HALF - TOL);
  localparam logic [CW-1:0] WIN_HI    = CW'(TOL);
  localparam logic [CW-1:0] GAP_END   = CW'(HALF - HALF / 2);
  localparam logic [5:0]    LAST_HALF = 6'd33;

  function automatic lvl_t line_level(input logic p, input logic n);
    lvl_t l;
    case ({p, n})
      2'b10:   l = LV_HI;
      2'b01:   l = LV_LO;
      default: l = LV_IDLE;
    endcase
    return l;
  endfunction

  // A valid Manchester bit has two defined, opposite half levels.
  function automatic logic manch_bad(input lvl_t first, input lvl_t second);
    return (first == LV_IDLE) || (second == LV_IDLE) || (first == second);
  endfunction

  // Synchronizer stages
  logic milp_p0, milp_p1, miln_p0, miln_p1;
  lvl_t lvl, lvl_p2;

  state_t      state, state_n;
  logic [CW-1:0] cnt, cnt_n;      // sync length / time since t0 / half-bit phase / gap
  logic [5:0]  hidx, hidx_n;      // data half-bit index 0..33
  lvl_t        ref_lvl, ref_n;    // level of the first sync half
  logic        svc, svc_n;
  logic        merr, merr_n;
  logic [15:0] shreg, shreg_n;
  lvl_t        first_lvl, first_n;

  logic        valid_q, valid_n;
  logic        service_q, service_n;
  logic [15:0] data_q, data_n;
  logic        error_q, error_n;
  logic [1:0]  code_q, code_n;

  logic bit_v, bad, merr_all, par_ok, edge_seen, in_window;

  assign lvl       = line_level(milp_p1, miln_p1);
  assign bit_v     = (first_lvl == LV_HI);
  assign bad       = manch_bad(first_lvl, lvl);
  assign merr_all  = merr | bad;
  assign par_ok    = ^{shreg, bit_v};
  assign edge_seen = (lvl != lvl_p2) && (lvl != LV_IDLE) && (lvl_p2 != LV_IDLE);
  // Mid-bit lies at the start of each odd half-bit; the window straddles it.
  assign in_window = hidx[0] ? (cnt <= WIN_HI) : (cnt >= WIN_LO);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hidx_n    = hidx;
    ref_n     = ref_lvl;
    svc_n     = svc;
    merr_n    = merr;
    shreg_n   = shreg;
    first_n   = first_lvl;
    valid_n   = 1'b0;
    service_n = service_q;
    data_n    = data_q;
    error_n   = error_q;
    code_n    = code_q;

    case (state)
      S_IDLE: begin
        if (lvl != LV_IDLE) begin
          state_n = S_SYNC1;
          ref_n   = lvl;
          cnt_n   = ONE;
        end
      end
      S_SYNC1: begin
        if (lvl == LV_IDLE) begin
          state_n = S_IDLE;
        end else if (lvl == ref_lvl) begin
          if (cnt >= SYNC_MAX) state_n = S_IDLE;
          else                 cnt_n   = cnt + ONE;
        end else if (cnt >= SYNC_MIN) begin
          // Mid-sync edge t0: all later timing is referenced to this cycle.
          state_n = S_SYNC2;
          svc_n   = (ref_lvl == LV_HI);
          merr_n  = 1'b0;
          cnt_n   = ONE;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_SYNC2: begin
        if (cnt == SYNC2_END) begin
          state_n = S_BIT;
          cnt_n   = '0;
          hidx_n  = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      S_BIT: begin
        if (cnt == PH_LAST) begin
          cnt_n  = '0;
          hidx_n = hidx + 6'd1;
        end else begin
          cnt_n = cnt + ONE;
        end
        if (cnt == PH_SAMP) begin
          if (!hidx[0]) begin
            first_n = lvl;
          end else begin
            merr_n = merr_all;
            if (hidx == LAST_HALF) begin
              valid_n   = 1'b1;
              service_n = svc;
              data_n    = shreg;
              error_n   = merr_all | ~par_ok;
              code_n    = merr_all ? 2'b01 : (par_ok ? 2'b00 : 2'b10);
              state_n   = S_GAP;
              cnt_n     = ONE;
            end else begin
              shreg_n = {shreg[14:0], bit_v};
            end
          end
        end
        // Snap to the nominal mid-bit point; the next cycle is phase 1.
        if (edge_seen && in_window) begin
          hidx_n = {hidx[5:1], 1'b1};
          cnt_n  = ONE;
        end
      end
      S_GAP: begin
        if (cnt == GAP_END) begin
          // This cycle is the first sample after nominal word end.
          if (lvl != LV_IDLE) begin
            state_n = S_SYNC1;
            ref_n   = lvl;
            cnt_n   = ONE;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Control, synchronizer and output registers
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      milp_p0   <= 1'b0;
      milp_p1   <= 1'b0;
      miln_p0   <= 1'b0;
      miln_p1   <= 1'b0;
      lvl_p2    <= LV_IDLE;
      state     <= S_IDLE;
      cnt       <= '0;
      hidx      <= '0;
      ref_lvl   <= LV_IDLE;
      svc       <= 1'b0;
      merr      <= 1'b0;
      valid_q   <= 1'b0;
      service_q <= 1'b0;
      data_q    <= '0;
      error_q   <= 1'b0;
      code_q    <= 2'b00;
    end else begin
      milp_p0   <= bus.milP;
      milp_p1   <= milp_p0;
      miln_p0   <= bus.milN;
      miln_p1   <= miln_p0;
      lvl_p2    <= lvl;
      state     <= state_n;
      cnt       <= cnt_n;
      hidx      <= hidx_n;
      ref_lvl   <= ref_n;
      svc       <= svc_n;
      merr      <= merr_n;
      valid_q   <= valid_n;
      service_q <= service_n;
      data_q    <= data_n;
      error_q   <= error_n;
      code_q    <= code_n;
    end
  end

  // Decode datapath registers
  always_ff @(posedge clk) begin
    shreg     <= shreg_n;
    first_lvl <= first_n;
  end

  assign bus.rxValid   = valid_q;
  assign bus.rxService = service_q;
  assign bus.rxData    = data_q;
  assign bus.rxError   = error_q;
  assign bus.rxErrCode = code_q;
  assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_mil_receiver.sv
// tb_mil_receiver
//   Directed bench for mil_receiver: drives Manchester-II words on milP/milN
//   and checks the decoded strobes against hand-computed values.
module tb_mil_receiver;
  localparam int HALF = 25;
  localparam int TOL  = 4;
  localparam int LO = 0;
  localparam int HI = 1;
  localparam int ID = 2;

  logic clk = 1'b0;
  logic nRst;

  mil_receiver_if bus();

  mil_receiver #(.HALF(HALF), .TOL(TOL)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Strobe monitor, sampled 1 time unit after the active edge
  int          cyc = 0;
  int          n_strobe = 0;
  int          vrun = 0;
  int          max_run = 0;
  int          busy_low = 0;
  int          last_cyc = 0, prev_cyc = 0;
  logic [15:0] last_data = '0, prev_data = '0;
  logic        last_svc = 1'b0, prev_svc = 1'b0, last_err = 1'b0;
  logic [1:0]  last_code = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (bus.rxValid) begin
      vrun++;
      n_strobe++;
      prev_cyc  = last_cyc;
      prev_data = last_data;
      prev_svc  = last_svc;
      last_cyc  = cyc;
      last_data = bus.rxData;
      last_svc  = bus.rxService;
      last_err  = bus.rxError;
      last_code = bus.rxErrCode;
    end else begin
      vrun = 0;
    end
    if (vrun > max_run) max_run = vrun;
    if (!bus.busy) busy_low++;
  end

  task automatic hold(input int lv, input int n);
    bus.milP = (lv == HI);
    bus.milN = (lv == LO);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_sync(input bit cmd, input int h);
    if (cmd) begin
      hold(HI, 3*h);
      hold(LO, 3*h);
    end else begin
      hold(LO, 3*h);
      hold(HI, 3*h);
    end
  endtask

  // Drives the first nh data half-bits; bad selects a bit whose halves are equal.
  task automatic send_bits(input logic [15:0] d, input bit par, input int h,
                           input int bad, input int nh);
    for (int k = 0; k < nh; k++) begin
      int   b;
      logic v;
      int   first;
      int   lv;
      b     = k / 2;
      v     = (b < 16) ? d[15-b] : par;
      first = v ? HI : LO;
      if (k % 2 == 0)   lv = first;
      else if (b == bad) lv = first;
      else              lv = 1 - first;
      hold(lv, h);
    end
  endtask

  task automatic send_word(input bit cmd, input logic [15:0] d, input bit par,
                           input int h, input int bad);
    send_sync(cmd, h);
    send_bits(d, par, h, bad, 34);
  endtask

  int s0, bl0, bl1;

  initial begin
    nRst = 1'b0;
    hold(ID, 4);
    chk("rst_valid", {31'd0, bus.rxValid}, 32'd0);
    chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
    chk("rst_data",  {16'd0, bus.rxData}, 32'd0);
    chk("rst_err",   {31'd0, bus.rxError}, 32'd0);
    chk("rst_code",  {30'd0, bus.rxErrCode}, 32'd0);
    nRst = 1'b1;
    hold(ID, 10);

    // Command word 0x02A1, parity 1
    s0 = n_strobe;
    send_word(1'b1, 16'h02A1, 1'b1, HALF, -1);
    hold(ID, 60);
    chk("cmd_count", n_strobe - s0, 32'd1);
    chk("cmd_svc",   {31'd0, last_svc}, 32'd1);
    chk("cmd_data",  {16'd0, last_data}, 32'h02A1);
    chk("cmd_err",   {31'd0, last_err}, 32'd0);
    chk("cmd_code",  {30'd0, last_code}, 32'd0);
    chk("cmd_held",  {16'd0, bus.rxData}, 32'h02A1);
    chk("cmd_idle_busy", {31'd0, bus.busy}, 32'd0);

    // Command word followed back-to-back by a data word
    s0 = n_strobe;
    send_sync(1'b1, HALF);
    bl0 = busy_low;
    send_bits(16'h02A1, 1'b1, HALF, -1, 34);
    send_sync(1'b0, HALF);
    send_bits(16'h02A1, 1'b1, HALF, -1, 34);
    bl1 = busy_low;
    hold(ID, 60);
    chk("ctg_count",   n_strobe - s0, 32'd2);
    chk("ctg_spacing", last_cyc - prev_cyc, 32'd1000);
    chk("ctg_svc1",    {31'd0, prev_svc}, 32'd1);
    chk("ctg_svc2",    {31'd0, last_svc}, 32'd0);
    chk("ctg_data1",   {16'd0, prev_data}, 32'h02A1);
    chk("ctg_data2",   {16'd0, last_data}, 32'h02A1);
    chk("ctg_busy",    bl1 - bl0, 32'd0);

    // Data word with parity bit 0 -> parity error
    s0 = n_strobe;
    send_word(1'b0, 16'h02A1, 1'b0, HALF, -1);
    hold(ID, 60);
    chk("par_count", n_strobe - s0, 32'd1);
    chk("par_svc",   {31'd0, last_svc}, 32'd0);
    chk("par_err",   {31'd0, last_err}, 32'd1);
    chk("par_code",  {30'd0, last_code}, 32'd2);
    chk("par_data",  {16'd0, last_data}, 32'h02A1);

    // Bit 5 with equal halves -> Manchester error
    s0 = n_strobe;
    send_word(1'b1, 16'h02A1, 1'b1, HALF, 5);
    hold(ID, 60);
    chk("man_count", n_strobe - s0, 32'd1);
    chk("man_err",   {31'd0, last_err}, 32'd1);
    chk("man_code",  {30'd0, last_code}, 32'd1);
    chk("man_data",  {16'd0, last_data}, 32'h02A1);

    // Sync first half only 50 clocks -> silent discard
    s0 = n_strobe;
    hold(HI, 50);
    hold(LO, 75);
    hold(ID, 60);
    chk("sync_count", n_strobe - s0, 32'd0);
    chk("sync_busy",  {31'd0, bus.busy}, 32'd0);

    // 26-clock half-bits, 0xFFFF parity 1, decoded through mid-bit resync
    s0 = n_strobe;
    send_word(1'b1, 16'hFFFF, 1'b1, 26, -1);
    hold(ID, 60);
    chk("slow_count", n_strobe - s0, 32'd1);
    chk("slow_data",  {16'd0, last_data}, 32'hFFFF);
    chk("slow_err",   {31'd0, last_err}, 32'd0);
    chk("slow_svc",   {31'd0, last_svc}, 32'd1);

    // Reset pulsed during bit 8
    s0 = n_strobe;
    send_sync(1'b1, HALF);
    send_bits(16'h5555, 1'b1, HALF, -1, 17);
    nRst = 1'b0;
    hold(LO, 2);
    chk("mid_rst_data",  {16'd0, bus.rxData}, 32'd0);
    chk("mid_rst_busy",  {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_valid", {31'd0, bus.rxValid}, 32'd0);
    chk("mid_rst_svc",   {31'd0, bus.rxService}, 32'd0);
    nRst = 1'b1;
    hold(LO, 40);
    hold(HI, 25);
    hold(ID, 60);
    chk("mid_rst_count", n_strobe - s0, 32'd0);
    chk("mid_rst_idle",  {31'd0, bus.busy}, 32'd0);

    s0 = n_strobe;
    send_word(1'b0, 16'h1234, 1'b0, HALF, -1);
    hold(ID, 60);
    chk("post_count", n_strobe - s0, 32'd1);
    chk("post_data",  {16'd0, last_data}, 32'h1234);
    chk("post_err",   {31'd0, last_err}, 32'd0);
    chk("post_svc",   {31'd0, last_svc}, 32'd0);

    chk("valid_width", max_run, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
